osd_status_sequencer: RTL and testbench

- Upstream controller for the OSD string writer. Watches per-row string-index selections and repaints changed OSD rows in the character RAM.
- Each repaint has two steps: blank the row with a fill character, then issue one start/string_index/base_addr request to the string writer. It then follows the writer's busy to completion.
- Its clear-write port and the writer's write port are OR-merged in front of the OSD character RAM. Both are never active in the same cycle.

---
 rtl/osd_status_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_osd_status_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_status_sequencer.sv
// osd_status_sequencer
//   Upstream controller for the OSD string writer. Tracks per-row string-index
//   selections, and for every row whose selection changed (or on refresh) it
//   blanks the row in character RAM and then asks the string writer to paint
//   the new string, following the writer's busy handshake to completion.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   row_idx           packed 6-bit string index per row (6'h3F = blank only)
//   refresh           one-cycle pulse, marks every row dirty
//   wr_busy           busy from the string writer
//   wr_start         one-cycle start request to the writer
//   wr_string_index   string index for the writer
//   wr_base_addr      char-RAM address where the writer places the string
//   clr_wr_en/addr/data  blanking write port into the char RAM
//   seq_busy          high while a repaint is in progress or pending
//   timeout_err       sticky flag, writer never raised busy after a start
module osd_status_sequencer #(
    parameter int          NUM_ROWS     = 4,
    parameter logic [10:0] BASE_ADDR    = 11'd0,
    parameter int          ROW_STRIDE   = 32,
    parameter int          ROW_CHARS    = 32,
    parameter int          COL_OFFSET   = 1,
    parameter logic [7:0]  FILL_CHAR    = 8'h20,
    parameter int          BUSY_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6*NUM_ROWS-1:0] row_idx,
    input  logic                  refresh,
    input  logic                  wr_busy,
    output logic                  wr_start,
    output logic [5:0]            wr_string_index,
    output logic [10:0]           wr_base_addr,
    output logic                  clr_wr_en,
    output logic [10:0]           clr_wr_addr,
    output logic [7:0]            clr_wr_data,
    output logic                  seq_busy,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t                state;
    logic [6*NUM_ROWS-1:0] prev_idx;
    logic [NUM_ROWS-1:0]   dirty;
    logic [10:0]           row_base;
    logic [5:0]            cur_idx;
    logic [10:0]           col;
    logic [15:0]           tmo;

    logic [NUM_ROWS-1:0]   change_mask;
    logic [NUM_ROWS-1:0]   pick_mask;
    logic [NUM_ROWS-1:0]   clr_mask;
    logic [NUM_ROWS-1:0]   dirty_next;
    logic                  pick_found;
    logic [5:0]            pick_idx;
    logic [10:0]           pick_base;
    logic                  last_col;
    logic                  tmo_done;
    logic                  to_idle;

    // Change detection and lowest-set-bit row selection.
    always_comb begin
        change_mask = '0;
        pick_mask   = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_base   = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            change_mask[r] = (row_idx[6*r +: 6] != prev_idx[6*r +: 6]);
            if (dirty[r] && !pick_found) begin
                pick_found   = 1'b1;
                pick_mask[r] = 1'b1;
                pick_idx     = row_idx[6*r +: 6];
                pick_base    = BASE_ADDR + 11'(r * ROW_STRIDE);
            end
        end
    end

    always_comb begin
        last_col   = (col == 11'(ROW_CHARS - 1));
        tmo_done   = (tmo == 16'(BUSY_TIMEOUT - 1));
        clr_mask   = (state == S_IDLE) ? pick_mask : '0;
        // Set wins over clear: a row re-marked while being picked stays dirty.
        dirty_next = (dirty & ~clr_mask) | (refresh ? '1 : change_mask);
        // Mirrors every FSM path that lands in IDLE this cycle, so seq_busy can
        // be registered yet still equal (state != IDLE) | (|dirty).
        unique case (state)
            S_IDLE:    to_idle = !pick_found;
            S_CLEAR:   to_idle = last_col && (cur_idx == 6'h3F);
            S_START:   to_idle = 1'b0;
            S_WAIT_HI: to_idle = !wr_busy && tmo_done;
            S_WAIT_LO: to_idle = !wr_busy;
            default:   to_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            prev_idx        <= '0;
            dirty           <= '1;
            row_base        <= '0;
            cur_idx         <= '0;
            col             <= '0;
            tmo             <= '0;
            wr_start        <= 1'b0;
            wr_string_index <= '0;
            wr_base_addr    <= '0;
            clr_wr_en       <= 1'b0;
            clr_wr_addr     <= '0;
            clr_wr_data     <= '0;
            seq_busy        <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            prev_idx <= row_idx;
            dirty    <= dirty_next;
            seq_busy <= !to_idle || (|dirty_next);

            unique case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        cur_idx     <= pick_idx;
                        row_base    <= pick_base;
                        col         <= '0;
                        clr_wr_en   <= 1'b1;
                        clr_wr_addr <= pick_base;
                        clr_wr_data <= FILL_CHAR;
                        state       <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    if (last_col) begin
                        clr_wr_en   <= 1'b0;
                        clr_wr_addr <= '0;
                        clr_wr_data <= '0;
                        if (cur_idx == 6'h3F) begin
                            state <= S_IDLE;
                        end else begin
                            wr_start        <= 1'b1;
                            wr_string_index <= cur_idx;
                            wr_base_addr    <= row_base + 11'(COL_OFFSET);
                            state           <= S_START;
                        end
                    end else begin
                        col         <= col + 11'd1;
                        clr_wr_addr <= row_base + col + 11'd1;
                    end
                end

                S_START: begin
                    wr_start <= 1'b0;
                    tmo      <= '0;
                    state    <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (wr_busy) begin
                        state <= S_WAIT_LO;
                    end else if (tmo_done) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end

                S_WAIT_LO: begin
                    if (!wr_busy) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_status_sequencer.sv
// tb_osd_status_sequencer
//   Scoreboard bench for osd_status_sequencer. Stimulus pushes the expected
//   char-RAM blank writes and writer start requests for every row it causes to
//   be repainted; a monitor pops and compares each event the DUT emits. A
//   simple string-writer model answers start requests with random latency.
module tb_osd_status_sequencer;

    localparam int          NR     = 4;
    localparam logic [10:0] BASE   = 11'd0;
    localparam int          STRIDE = 32;
    localparam int          CHARS  = 32;
    localparam int          COLOFF = 1;
    localparam logic [7:0]  FILL   = 8'h20;
    localparam int          TMO    = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [6*NR-1:0] row_idx;
    logic            refresh;
    logic            wr_busy;
    logic            wr_start;
    logic [5:0]      wr_string_index;
    logic [10:0]     wr_base_addr;
    logic            clr_wr_en;
    logic [10:0]     clr_wr_addr;
    logic [7:0]      clr_wr_data;
    logic            seq_busy;
    logic            timeout_err;

    osd_status_sequencer #(
        .NUM_ROWS    (NR),
        .BASE_ADDR   (BASE),
        .ROW_STRIDE  (STRIDE),
        .ROW_CHARS   (CHARS),
        .COL_OFFSET  (COLOFF),
        .FILL_CHAR   (FILL),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .row_idx        (row_idx),
        .refresh        (refresh),
        .wr_busy        (wr_busy),
        .wr_start       (wr_start),
        .wr_string_index(wr_string_index),
        .wr_base_addr   (wr_base_addr),
        .clr_wr_en      (clr_wr_en),
        .clr_wr_addr    (clr_wr_addr),
        .clr_wr_data    (clr_wr_data),
        .seq_busy       (seq_busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_start;
        logic [10:0] addr;
        logic [7:0]  val;
    } ev_t;

    ev_t expq[$];
    int  cur[NR];
    int  total = 0;
    int  bad = 0;
    bit  dead_once = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_flag(string name, bit ok, string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s (t=%0t)", name, detail, $time);
        end
    endtask

    // Reference: a row repaint is CHARS blanks across the row, then a start
    // at column COLOFF unless the index is the blank-only code.
    function automatic logic [10:0] row_addr(int r, int c);
        return 11'(int'(BASE) + r * STRIDE + c);
    endfunction

    task automatic push_pass(int r, int idx);
        for (int c = 0; c < CHARS; c++)
            expq.push_back('{1'b0, row_addr(r, c), FILL});
        if (idx != 63)
            expq.push_back('{1'b1, row_addr(r, COLOFF), 8'(idx)});
    endtask

    task automatic push_all();
        for (int r = 0; r < NR; r++) push_pass(r, cur[r]);
    endtask

    task automatic set_row(int r, int v);
        cur[r] = v;
        row_idx[6*r +: 6] = 6'(v);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_wr_start"}, 32'(wr_start), 0);
        check({tag, "_wr_idx"}, 32'(wr_string_index), 0);
        check({tag, "_wr_base"}, 32'(wr_base_addr), 0);
        check({tag, "_clr_en"}, 32'(clr_wr_en), 0);
        check({tag, "_clr_addr"}, 32'(clr_wr_addr), 0);
        check({tag, "_clr_data"}, 32'(clr_wr_data), 0);
        check({tag, "_seq_busy"}, 32'(seq_busy), 0);
        check({tag, "_timeout"}, 32'(timeout_err), 0);
    endtask

    task automatic wait_idle(string name);
        bit ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0 && !seq_busy && !wr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_flag(name, ok, $sformatf("not idle, %0d events pending, seq_busy=%0b", expq.size(), seq_busy));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_blank_at(string name, logic [10:0] a);
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (clr_wr_en && clr_wr_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
        check_flag(name, ok, $sformatf("no blank write at %0h", a));
    endtask

    // Monitor / scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (clr_wr_en || wr_start) begin
                check("port_exclusive", 32'(clr_wr_en & wr_start), 0);
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got en=%0b addr=%0h start=%0b idx=%0h, expected none",
                             clr_wr_en, clr_wr_addr, wr_start, wr_string_index);
                end else begin
                    e = expq.pop_front();
                    check("event_kind", 32'(wr_start), 32'(e.is_start));
                    if (e.is_start) begin
                        check("start_idx", 32'(wr_string_index), 32'(e.val));
                        check("start_base", 32'(wr_base_addr), 32'(e.addr));
                    end else begin
                        check("blank_addr", 32'(clr_wr_addr), 32'(e.addr));
                        check("blank_data", 32'(clr_wr_data), 32'(e.val));
                    end
                end
            end
        end
    end

    // String-writer model: raises busy a short while after start.
    initial begin
        wr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_start) begin
                if (dead_once) begin
                    dead_once = 1'b0;
                end else begin
                    int d;
                    int l;
                    d = int'($urandom_range(0, 2));
                    l = int'($urandom_range(2, 5));
                    repeat (d) @(negedge clk);
                    wr_busy = 1'b1;
                    repeat (l) @(negedge clk);
                    wr_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int a;
        int b;
        bit ok;
        bit changed[NR];

        reset_n = 1'b0;
        refresh = 1'b0;
        row_idx = '0;
        set_row(0, 0);
        set_row(1, 10);
        set_row(2, 16);
        set_row(3, 35);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // 1: full repaint after reset
        push_all();
        reset_n = 1'b1;
        wait_idle("t1_full_repaint");
        check("t1_timeout_clear", 32'(timeout_err), 0);

        // 2: single row change
        set_row(2, 17);
        push_pass(2, 17);
        wait_idle("t2_row2_repaint");

        // 3: blank-only row
        set_row(1, 63);
        push_pass(1, 63);
        wait_idle("t3_blank_only");

        // random rounds
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                push_all();
                pulse_refresh();
            end else begin
                for (int r = 0; r < NR; r++) begin
                    int v;
                    changed[r] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        v = int'($urandom_range(0, 63));
                        if (v != cur[r]) begin
                            set_row(r, v);
                            changed[r] = 1'b1;
                        end
                    end
                end
                for (int r = 0; r < NR; r++)
                    if (changed[r]) push_pass(r, cur[r]);
            end
            wait_idle("rand_round");
        end

        // 4: writer never raises busy on one start
        check("t4_err_before", 32'(timeout_err), 0);
        dead_once = 1'b1;
        set_row(1, (cur[1] == 7) ? 8 : 7);
        set_row(2, (cur[2] == 9) ? 12 : 9);
        push_pass(1, cur[1]);
        push_pass(2, cur[2]);
        ok = 1'b0;
        c0 = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (wr_start) begin
                ok = 1'b1;
                c0 = cyc;
                break;
            end
        end
        check_flag("t4_start_seen", ok, "no wr_start");
        ok = 1'b0;
        c1 = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (timeout_err) begin
                ok = 1'b1;
                c1 = cyc;
                break;
            end
        end
        check_flag("t4_timeout_seen", ok, "timeout_err never set");
        // one START cycle plus TMO cycles in WAIT_HI
        check("t4_timeout_latency", 32'(c1 - c0), 32'(TMO + 1));
        wait_idle("t4_next_row");
        check("t4_err_sticky", 32'(timeout_err), 1);

        // 5: row0 changed mid-clear, then refresh during writer busy
        a = (cur[0] == 21) ? 22 : 21;
        b = 40;
        set_row(0, a);
        push_pass(0, a);
        wait_blank_at("t5_col10", row_addr(0, 10));
        set_row(0, b);
        push_pass(0, b);
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (wr_start && wr_string_index == 6'(b)) begin
                ok = 1'b1;
                break;
            end
        end
        check_flag("t5_new_start", ok, "no start with new index");
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (wr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_flag("t5_writer_busy", ok, "writer busy not seen");
        push_all();
        pulse_refresh();
        wait_idle("t5_refresh_repaint");
        check("t5_err_sticky", 32'(timeout_err), 1);

        // 6: async reset mid-clear, then full repaint
        push_all();
        pulse_refresh();
        wait_blank_at("t6_mid_clear", row_addr(1, 5));
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        expq.delete();
        repeat (2) @(negedge clk);
        // prev_idx restarts at 0, so a non-zero row0 index is seen as a change
        // at the same edge row0 is picked, and row0 is painted twice.
        push_pass(0, cur[0]);
        if (cur[0] != 0) push_pass(0, cur[0]);
        for (int r = 1; r < NR; r++) push_pass(r, cur[r]);
        reset_n = 1'b1;
        wait_idle("t6_repaint");
        check("t6_err_cleared", 32'(timeout_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
